// File: rtl/unidade_adiantamento.sv
// rtl/unidade_adiantamento.sv - forwarding and load-use hazard unit for the 5-stage datapath
// Tracks EX/MEM/WB destinations and drives the EX operand mux selectors and stall.
module unidade_adiantamento #(
    parameter int REG_BITS  = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 habilita,
    input  logic                 flush,
    input  logic [REG_BITS-1:0]  rs_id,
    input  logic [REG_BITS-1:0]  rt_id,
    input  logic                 usa_rt_id,
    input  logic [REG_BITS-1:0]  rd_id,
    input  logic                 escreve_id,
    input  logic                 le_mem_id,
    output logic [1:0]           seletor_a,
    output logic [1:0]           seletor_b,
    output logic                 parada,
    output logic [CNT_WIDTH-1:0] contador_paradas
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic [REG_BITS-1:0]  r_rs_ex;
    logic [REG_BITS-1:0]  r_rt_ex;
    logic [REG_BITS-1:0]  r_dst_ex;
    logic                 r_wr_ex;
    logic                 r_ld_ex;
    logic [REG_BITS-1:0]  r_dst_mem;
    logic                 r_wr_mem;
    logic [REG_BITS-1:0]  r_dst_wb;
    logic                 r_wr_wb;
    logic [CNT_WIDTH-1:0] r_contador;

    logic                 w_risco;
    logic                 w_mem_valido;
    logic                 w_wb_valido;

    // A load in EX cannot forward yet; the reader in ID must wait one cycle.
    always_comb begin
        w_risco = r_ld_ex && (r_dst_ex != '0) &&
                  ((r_dst_ex == rs_id) || (usa_rt_id && (r_dst_ex == rt_id)));
    end

    assign parada           = w_risco && !flush;
    assign contador_paradas = r_contador;

    assign w_mem_valido = r_wr_mem && (r_dst_mem != '0);
    assign w_wb_valido  = r_wr_wb  && (r_dst_wb  != '0);

    // MEM is checked first so the newest producer wins.
    always_comb begin
        seletor_a = SEL_RF;
        if (w_mem_valido && (r_dst_mem == r_rs_ex)) begin
            seletor_a = SEL_MEM;
        end else if (w_wb_valido && (r_dst_wb == r_rs_ex)) begin
            seletor_a = SEL_WB;
        end
    end

    always_comb begin
        seletor_b = SEL_RF;
        if (w_mem_valido && (r_dst_mem == r_rt_ex)) begin
            seletor_b = SEL_MEM;
        end else if (w_wb_valido && (r_dst_wb == r_rt_ex)) begin
            seletor_b = SEL_WB;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rs_ex    <= '0;
            r_rt_ex    <= '0;
            r_dst_ex   <= '0;
            r_wr_ex    <= 1'b0;
            r_ld_ex    <= 1'b0;
            r_dst_mem  <= '0;
            r_wr_mem   <= 1'b0;
            r_dst_wb   <= '0;
            r_wr_wb    <= 1'b0;
            r_contador <= '0;
        end else if (habilita) begin
            r_dst_wb  <= r_dst_mem;
            r_wr_wb   <= r_wr_mem;
            r_dst_mem <= r_dst_ex;
            r_wr_mem  <= r_wr_ex;
            if (flush || parada) begin
                r_rs_ex  <= '0;
                r_rt_ex  <= '0;
                r_dst_ex <= '0;
                r_wr_ex  <= 1'b0;
                r_ld_ex  <= 1'b0;
            end else begin
                r_rs_ex  <= rs_id;
                r_rt_ex  <= rt_id;
                r_dst_ex <= rd_id;
                r_wr_ex  <= escreve_id;
                r_ld_ex  <= le_mem_id;
            end
            if (parada) begin
                r_contador <= r_contador + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_unidade_adiantamento.sv
// tb/tb_unidade_adiantamento.sv - scoreboard bench for unidade_adiantamento
// Each row drives one cycle of ID inputs and carries the outputs expected before the next edge.
module tb_unidade_adiantamento;

    logic        clock;
    logic        reset;
    logic        habilita;
    logic        flush;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        usa_rt_id;
    logic [4:0]  rd_id;
    logic        escreve_id;
    logic        le_mem_id;
    logic [1:0]  seletor_a;
    logic [1:0]  seletor_b;
    logic        parada;
    logic [31:0] contador_paradas;

    typedef struct {
        logic        rst;
        logic        hab;
        logic        fl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        usa;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        chk;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic        par;
        logic [31:0] cnt;
    } vec_t;

    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    unidade_adiantamento #(.REG_BITS(5), .CNT_WIDTH(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .habilita         (habilita),
        .flush            (flush),
        .rs_id            (rs_id),
        .rt_id            (rt_id),
        .usa_rt_id        (usa_rt_id),
        .rd_id            (rd_id),
        .escreve_id       (escreve_id),
        .le_mem_id        (le_mem_id),
        .seletor_a        (seletor_a),
        .seletor_b        (seletor_b),
        .parada           (parada),
        .contador_paradas (contador_paradas)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic hab, input logic fl,
                                input logic [4:0] rs, input logic [4:0] rt, input logic usa,
                                input logic [4:0] rd, input logic wr, input logic ld,
                                input logic chk, input logic [1:0] sa, input logic [1:0] sb,
                                input logic par, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.hab = hab; v.fl = fl; v.rs = rs; v.rt = rt; v.usa = usa;
        v.rd = rd; v.wr = wr; v.ld = ld; v.chk = chk; v.sa = sa; v.sb = sb;
        v.par = par; v.cnt = cnt;
        return v;
    endfunction

    function automatic vec_t rst_row();
        return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; habilita = v.hab; flush = v.fl;
        rs_id = v.rs; rt_id = v.rt; usa_rt_id = v.usa;
        rd_id = v.rd; escreve_id = v.wr; le_mem_id = v.ld;
    endtask

    task automatic test_reset();
        vec_t v[$];
        vec_t e;
        v.push_back(rst_row());
        for (int k = 0; k < 10; k++)
            v.push_back(mk(0, 1, 0, 5'($urandom_range(31)), 5'($urandom_range(31)),
                           1'($urandom_range(1)), 5'($urandom_range(31)), 0, 0,
                           1, 2'b00, 2'b00, 0, 0));
        foreach (v[i]) begin
            drive(v[i]);
            if (v[i].chk) sb_q.push_back(v[i]);
            @(negedge clock);
            if (v[i].chk) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({seletor_a, seletor_b, parada, contador_paradas} !== {e.sa, e.sb, e.par, e.cnt}) begin
                    n_err++;
                    $display("FAIL reset[%0d]: got sa=%b sb=%b par=%b cnt=%0d want sa=%b sb=%b par=%b cnt=%0d",
                             i, seletor_a, seletor_b, parada, contador_paradas, e.sa, e.sb, e.par, e.cnt);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_forward();
        vec_t v[$];
        vec_t e;
        v.push_back(rst_row());
        v.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 8, 9, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 1, 2, 1, 5, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 8, 9, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        foreach (v[i]) begin
            drive(v[i]);
            if (v[i].chk) sb_q.push_back(v[i]);
            @(negedge clock);
            if (v[i].chk) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({seletor_a, seletor_b, parada, contador_paradas} !== {e.sa, e.sb, e.par, e.cnt}) begin
                    n_err++;
                    $display("FAIL forward[%0d]: got sa=%b sb=%b par=%b cnt=%0d want sa=%b sb=%b par=%b cnt=%0d",
                             i, seletor_a, seletor_b, parada, contador_paradas, e.sa, e.sb, e.par, e.cnt);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        vec_t e;
        v.push_back(rst_row());
        v.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 8, 8, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        foreach (v[i]) begin
            drive(v[i]);
            if (v[i].chk) sb_q.push_back(v[i]);
            @(negedge clock);
            if (v[i].chk) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({seletor_a, seletor_b, parada, contador_paradas} !== {e.sa, e.sb, e.par, e.cnt}) begin
                    n_err++;
                    $display("FAIL back_to_back[%0d]: got sa=%b sb=%b par=%b cnt=%0d want sa=%b sb=%b par=%b cnt=%0d",
                             i, seletor_a, seletor_b, parada, contador_paradas, e.sa, e.sb, e.par, e.cnt);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_load_use();
        vec_t v[$];
        vec_t e;
        v.push_back(rst_row());
        v.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 1, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 3, 10, 1, 11, 1, 0, 1, 2'b00, 2'b00, 1, 0));
        v.push_back(mk(0, 1, 0, 3, 10, 1, 11, 1, 0, 1, 2'b00, 2'b00, 0, 1));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 1));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 1, 1, 2'b00, 2'b00, 0, 1));
        v.push_back(mk(0, 1, 0, 3, 10, 0, 11, 1, 0, 1, 2'b00, 2'b00, 0, 1));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 1));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1));
        foreach (v[i]) begin
            drive(v[i]);
            if (v[i].chk) sb_q.push_back(v[i]);
            @(negedge clock);
            if (v[i].chk) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({seletor_a, seletor_b, parada, contador_paradas} !== {e.sa, e.sb, e.par, e.cnt}) begin
                    n_err++;
                    $display("FAIL load_use[%0d]: got sa=%b sb=%b par=%b cnt=%0d want sa=%b sb=%b par=%b cnt=%0d",
                             i, seletor_a, seletor_b, parada, contador_paradas, e.sa, e.sb, e.par, e.cnt);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_flush();
        vec_t v[$];
        vec_t e;
        v.push_back(rst_row());
        v.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 1, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 1, 10, 0, 0, 12, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 12, 12, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        foreach (v[i]) begin
            drive(v[i]);
            if (v[i].chk) sb_q.push_back(v[i]);
            @(negedge clock);
            if (v[i].chk) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({seletor_a, seletor_b, parada, contador_paradas} !== {e.sa, e.sb, e.par, e.cnt}) begin
                    n_err++;
                    $display("FAIL flush[%0d]: got sa=%b sb=%b par=%b cnt=%0d want sa=%b sb=%b par=%b cnt=%0d",
                             i, seletor_a, seletor_b, parada, contador_paradas, e.sa, e.sb, e.par, e.cnt);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_hold_and_reset();
        vec_t v[$];
        vec_t e;
        v.push_back(rst_row());
        v.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 8, 9, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 1, 1, 2'b00, 2'b00, 0, 0));
        v.push_back(mk(0, 0, 0, 10, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0));
        v.push_back(mk(0, 0, 0, 10, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0));
        v.push_back(mk(0, 1, 0, 10, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 1, 1, 2'b00, 2'b00, 0, 1));
        v.push_back(mk(1, 1, 0, 10, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1));
        v.push_back(mk(0, 1, 0, 10, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        foreach (v[i]) begin
            drive(v[i]);
            if (v[i].chk) sb_q.push_back(v[i]);
            @(negedge clock);
            if (v[i].chk) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({seletor_a, seletor_b, parada, contador_paradas} !== {e.sa, e.sb, e.par, e.cnt}) begin
                    n_err++;
                    $display("FAIL hold_reset[%0d]: got sa=%b sb=%b par=%b cnt=%0d want sa=%b sb=%b par=%b cnt=%0d",
                             i, seletor_a, seletor_b, parada, contador_paradas, e.sa, e.sb, e.par, e.cnt);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        drive(rst_row());
        @(posedge clock); #1;
        test_reset();
        test_forward();
        test_back_to_back();
        test_load_use();
        test_flush();
        test_hold_and_reset();
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_adiantamento.md
Name: unidade_adiantamento

Overview:
- Sequential forwarding and hazard unit for the 5-stage 32-bit datapath.
- Tracks destination register and write-enable of instructions in EX, MEM and WB.
- Drives the 2-bit selectors of the two EX-stage ALU operand 3-input muxes.
- Raises a load-use stall and counts stall cycles for performance inspection.

Parameters:
- REG_BITS, 5, width of register specifiers.
- CNT_WIDTH, 32, width of stall-cycle counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- habilita  input  1  pipeline advance enable; 0 freezes all internal state
- flush  input  1  discard instruction leaving ID (taken branch/jump)
- rs_id  input  REG_BITS  rs of instruction in ID
- rt_id  input  REG_BITS  rt of instruction in ID
- usa_rt_id  input  1  instruction in ID reads rt
- rd_id  input  REG_BITS  destination register of instruction in ID
- escreve_id  input  1  instruction in ID writes register file
- le_mem_id  input  1  instruction in ID is a load
- seletor_a  output  2  operand-A mux select: 00 register file, 01 WB value, 10 MEM value
- seletor_b  output  2  operand-B mux select, same encoding
- parada  output  1  stall: hold PC and IF/ID, insert bubble into EX
- contador_paradas  output  CNT_WIDTH  cycles with parada=1 and habilita=1

Behaviour:
- Internal state:
  - EX entry: rs_ex, rt_ex, dst_ex, wr_ex, ld_ex
  - MEM entry: dst_mem, wr_mem
  - WB entry: dst_wb, wr_wb
  - stall counter
- Reset (synchronous, priority over everything):
  - all entries zero, so every wr/ld flag is 0 and the pipeline holds bubbles
  - counter 0
  - outputs: seletor_a=00, seletor_b=00, parada=0
- Hazard detection (combinational):
  - risco = ld_ex && dst_ex!=0 && (dst_ex==rs_id || (usa_rt_id && dst_ex==rt_id))
  - parada = risco && !flush, because a flushed instruction needs no stall
- Advance on rising edge when habilita=1:
  - WB <= MEM; MEM <= {dst_ex, wr_ex}.
  - If flush or parada: EX <= bubble, with wr_ex=0, ld_ex=0 and registers zeroed.
  - Else: EX <= {rs_id, rt_id, rd_id, escreve_id, le_mem_id}.
  - Counter increments when parada=1. It wraps modulo 2^CNT_WIDTH with no saturation.
- habilita=0:
  - every register holds, including the counter
  - combinational outputs still reflect the held state
- Forwarding (combinational from registered state, same cycle):
  - seletor_a = 10 if wr_mem && dst_mem!=0 && dst_mem==rs_ex
  - else 01 if wr_wb && dst_wb!=0 && dst_wb==rs_ex
  - else 00
  - seletor_b is identical with rt_ex.
  - MEM has priority over WB when both match (newest value wins).
  - Register 0 is never forwarded.
  - Encoding 11 is never produced.
- Latency:
  - an instruction presented in ID at edge N is in EX after N, in MEM after N+1, and in WB after N+2
  - forwarding is visible in the cycle following each edge
- Load-use behaviour:
  - one stall cycle is inserted
  - on the next cycle the load is in MEM
  - the dependent instruction is re-presented in ID, enters EX one cycle later, and gets 01 (WB forward)

Test Plan:
- Reset then idle → seletor_a=seletor_b=00, parada=0, contador_paradas=0 for 10 cycles with random rs/rt but escreve_id=0.
- ID: rd=8 escreve=1, then ID: rs=8 rt=9 → second instruction in EX sees seletor_a=10, seletor_b=00; insert one unrelated instruction between them instead → seletor_a=01.
- Back-to-back writes to $8 then reader rs=8 rt=8 → seletor_a=seletor_b=10 (MEM priority over WB); repeat with rd=0 on both writers → 00.
- Load rd=10 le_mem=1 followed by rs=3 rt=10 usa_rt=1 → parada=1 exactly one cycle, counter=1, the dependent instruction later in EX gets seletor_b=01; same with usa_rt=0 → no stall.
- Load-use hazard with flush=1 in the same cycle → parada=0, counter unchanged, EX holds a bubble next cycle (no forwarding from it).
- habilita=0 for 3 cycles during an active forward of seletor_a=10 → outputs and counter held; reset asserted mid-stall → next cycle all outputs 00/0 and counter 0.
